// File: rtl/layer0_input_quantizer.sv
// layer0_input_quantizer
//   Quantizes a stream of signed feature words to 2-bit codes against three
//   per-feature thresholds. The codes of one frame are packed into a flat
//   vector, which is then offered to layer 0 under a valid/ready handshake.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   s_valid/s_ready     : input word handshake
//   s_data              : signed feature word
//   s_last              : last word of the frame
//   m_valid/m_ready     : packed frame handshake
//   m_data              : packed codes, feature i at bits [2i+1:2i]
//   m_err               : frame-length error, qualified by m_valid
//   clip_lo_cnt/hi_cnt  : saturating counts of 2'b00 / 2'b11 codes
//                         (only when QUANT_CLIP_STATS_EN is defined)
//
// Optional feature macro: QUANT_CLIP_STATS_EN
module layer0_input_quantizer #(
  parameter int NUM_FEATURES = 64,
  parameter int IN_W         = 8,
  parameter int CNT_W        = 8,
  parameter logic [NUM_FEATURES*3*IN_W-1:0] THRESH = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_W-1:0]           s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*NUM_FEATURES-1:0] m_data,
  output logic                      m_err
`ifdef QUANT_CLIP_STATS_EN
  ,
  output logic [15:0]               clip_lo_cnt,
  output logic [15:0]               clip_hi_cnt
`endif
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_idx;
  logic [2*NUM_FEATURES-1:0] r_data;
  logic                      r_err;

  logic [IN_W-1:0] w_t0, w_t1, w_t2;
  logic [1:0]      w_code;
  logic            w_accept, w_last_beat, w_close;

  // Thresholds of the feature currently being filled.
  assign w_t0 = THRESH[(3*int'(r_idx)+0)*IN_W +: IN_W];
  assign w_t1 = THRESH[(3*int'(r_idx)+1)*IN_W +: IN_W];
  assign w_t2 = THRESH[(3*int'(r_idx)+2)*IN_W +: IN_W];

  always_comb begin
    w_code = 2'b11;
    if ($signed(s_data) < $signed(w_t0))      w_code = 2'b00;
    else if ($signed(s_data) < $signed(w_t1)) w_code = 2'b01;
    else if ($signed(s_data) < $signed(w_t2)) w_code = 2'b10;
  end

  assign w_accept    = s_valid && (r_state == FILL);
  assign w_last_beat = (r_idx == CNT_W'(NUM_FEATURES-1));
  assign w_close     = w_accept && (w_last_beat || s_last);

  // Next state and handshake outputs; both ready/valid depend on state only.
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    case (r_state)
      FILL: begin
        s_ready = 1'b1;
        if (w_close) w_state_nxt = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  // Frame assembly. Fields beyond an early s_last stay 2'b00 because the
  // vector is cleared whenever a frame is handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        FILL: if (w_accept) begin
          r_data[2*int'(r_idx) +: 2] <= w_code;
          if (w_close) begin
            r_idx <= '0;
            // Error when s_last and the final index disagree.
            r_err <= w_last_beat ^ s_last;
          end else begin
            r_idx <= r_idx + CNT_W'(1);
          end
        end
        HOLD: if (m_ready) begin
          r_data <= '0;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m_data = r_data;
  assign m_err  = r_err;

`ifdef QUANT_CLIP_STATS_EN
  logic [15:0] r_clip_lo_cnt, r_clip_hi_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clip_lo_cnt <= '0;
      r_clip_hi_cnt <= '0;
    end else if (w_accept) begin
      if (w_code == 2'b00 && r_clip_lo_cnt != 16'hFFFF)
        r_clip_lo_cnt <= r_clip_lo_cnt + 16'd1;
      if (w_code == 2'b11 && r_clip_hi_cnt != 16'hFFFF)
        r_clip_hi_cnt <= r_clip_hi_cnt + 16'd1;
    end
  end

  assign clip_lo_cnt = r_clip_lo_cnt;
  assign clip_hi_cnt = r_clip_hi_cnt;
`endif

endmodule

// File: tb/tb_layer0_input_quantizer.sv
module tb_layer0_input_quantizer;
  localparam int NF = 4;
  localparam int IW = 8;
  // Per feature {T2, T1, T0} = {16, 0, -16}.
  localparam logic [NF*3*IW-1:0] TH = {NF{8'h10, 8'h00, 8'hF0}};

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [IW-1:0] s_data;
  logic          m_valid, m_ready, m_err;
  logic [2*NF-1:0] m_data;
`ifdef QUANT_CLIP_STATS_EN
  logic [15:0] clip_lo_cnt, clip_hi_cnt;
`endif

  layer0_input_quantizer #(
    .NUM_FEATURES(NF), .IN_W(IW), .CNT_W(2), .THRESH(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
`ifdef QUANT_CLIP_STATS_EN
    , .clip_lo_cnt(clip_lo_cnt), .clip_hi_cnt(clip_hi_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] sb[$];  // {err, data} of frames driven, in order

  typedef struct {
    logic [3:0][7:0] x;        // x[0] is the first beat
    int              n;        // beats driven
    int              last_at;  // beat carrying s_last, -1 for none
    logic [7:0]      ed;
    logic            ee;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [3:0][7:0] x, input int n, input int last_at,
                            input logic [7:0] ed, input logic ee);
    sb.push_back({ee, ed});
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = x[b];
      s_last  = (b == last_at);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("latency_m_valid", {31'b0, m_valid}, 32'd1);
  endtask

  task automatic expect_frame(input int id);
    logic [8:0] e;
    int waited;
    waited = 0;
    while (!m_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    e = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
    if (!m_valid) begin
      checks++;
      failures++;
      $display("FAIL frame%0d_timeout actual=no_m_valid required=m_valid", id);
    end else begin
      chk($sformatf("frame%0d_data", id), {24'b0, m_data}, {24'b0, e[7:0]});
      chk($sformatf("frame%0d_err", id), {31'b0, m_err}, {31'b0, e[8]});
      chk($sformatf("frame%0d_s_ready_hold", id), {31'b0, s_ready}, 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk($sformatf("frame%0d_release_valid", id), {31'b0, m_valid}, 32'd0);
    chk($sformatf("frame%0d_release_ready", id), {31'b0, s_ready}, 32'd1);
    chk($sformatf("frame%0d_release_data", id), {24'b0, m_data}, 32'd0);
  endtask

  initial begin
    vt[0] = '{x: {8'h64, 8'h05, 8'hFF, 8'hEC}, n: 4, last_at: 3,  ed: 8'hE4, ee: 1'b0};
    vt[1] = '{x: {8'h0F, 8'h10, 8'h00, 8'hF0}, n: 4, last_at: 3,  ed: 8'hB9, ee: 1'b0};
    vt[2] = '{x: {8'h00, 8'h00, 8'h64, 8'h64}, n: 2, last_at: 1,  ed: 8'h0F, ee: 1'b1};
    vt[3] = '{x: {8'hF0, 8'hEF, 8'h7F, 8'h80}, n: 4, last_at: -1, ed: 8'h4C, ee: 1'b1};
    vt[4] = '{x: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, n: 4, last_at: 3,  ed: 8'h55, ee: 1'b0};
    vt[5] = '{x: {8'h00, 8'h00, 8'h00, 8'h00}, n: 1, last_at: 0,  ed: 8'h02, ee: 1'b1};
    vt[6] = '{x: {8'h00, 8'h10, 8'hEC, 8'h7F}, n: 3, last_at: 2,  ed: 8'h33, ee: 1'b1};

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    @(negedge clk);
    chk("reset_m_valid", {31'b0, m_valid}, 32'd0);
    chk("reset_s_ready", {31'b0, s_ready}, 32'd1);
    chk("reset_m_data", {24'b0, m_data}, 32'd0);
    chk("reset_m_err", {31'b0, m_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      send_frame(vt[v].x, vt[v].n, vt[v].last_at, vt[v].ed, vt[v].ee);
      expect_frame(v);
    end

    // Backpressure: beats offered during HOLD must not be consumed.
    send_frame(vt[0].x, 4, 3, vt[0].ed, 1'b0);
    s_valid = 1'b1; s_data = 8'h80; s_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_data_stable", {24'b0, m_data}, 32'hE4);
      chk("bp_s_ready", {31'b0, s_ready}, 32'd0);
      chk("bp_m_valid", {31'b0, m_valid}, 32'd1);
    end
    s_valid = 1'b0; s_last = 1'b0;
    expect_frame(10);
    send_frame(vt[1].x, 4, 3, vt[1].ed, 1'b0);
    expect_frame(11);

    // Reset in the middle of a frame.
    @(negedge clk); s_valid = 1'b1; s_data = 8'hEC; s_last = 1'b0;
    @(negedge clk); s_data = 8'hFF;
    @(negedge clk); s_valid = 1'b0;
    chk("mid_partial_data", {24'b0, m_data}, 32'h04);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("mid_rst_m_data", {24'b0, m_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(vt[0].x, 4, 3, vt[0].ed, 1'b0);
    expect_frame(12);

`ifdef QUANT_CLIP_STATS_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("stat_reset_lo", {16'b0, clip_lo_cnt}, 32'd0);
    for (int f = 0; f < 3; f++) begin
      send_frame(vt[0].x, 4, 3, vt[0].ed, 1'b0);
      expect_frame(20 + f);
    end
    chk("stat_lo_3", {16'b0, clip_lo_cnt}, 32'd3);
    chk("stat_hi_3", {16'b0, clip_hi_cnt}, 32'd3);
    force dut.r_clip_lo_cnt = 16'hFFFE;
    force dut.r_clip_hi_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_clip_lo_cnt;
    release dut.r_clip_hi_cnt;
    for (int f = 0; f < 2; f++) begin
      send_frame(vt[0].x, 4, 3, vt[0].ed, 1'b0);
      expect_frame(30 + f);
    end
    chk("stat_lo_sat", {16'b0, clip_lo_cnt}, 32'h0000FFFF);
    chk("stat_hi_sat", {16'b0, clip_hi_cnt}, 32'h0000FFFF);
`endif

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer0_input_quantizer.md
# layer0_input_quantizer

Front-end stage that feeds the layer-0 LUT neurons. It accepts a stream of signed fixed-point feature words, one per handshake. Each word is quantized to a 2-bit code against three per-feature thresholds, and the codes are packed into a flat vector. Once a whole frame is assembled, the vector is presented to layer 0 under a valid/ready handshake; the layer-0 fan-in wiring slices 2-bit fields from this vector.

## Interface
Parameters:
- NUM_FEATURES, 64: features per frame; range 2..256.
- IN_W, 8: signed input word width.
- CNT_W, 8: index counter width; must satisfy 2^CNT_W >= NUM_FEATURES.
- THRESH, 0: packed per-feature thresholds, NUM_FEATURES*3*IN_W bits.
  - Feature i, threshold j (j=0..2) sits at offset (3*i+j)*IN_W.
  - Required: T0 <= T1 <= T2 for each feature.

Ports:
- clk in 1: single clock; all state updates on the rising edge.
- rst in 1: asynchronous, active-high reset.
- s_valid in 1: input word valid.
- s_ready out 1: stage accepts a word.
- s_data in IN_W: signed feature value.
- s_last in 1: marks the final word of a frame.
- m_valid out 1: packed frame valid toward layer 0.
- m_ready in 1: layer 0 / pipeline accepts the frame.
- m_data out 2*NUM_FEATURES: packed codes.
  - Feature i occupies bits [2i+1:2i]; bit 2i is the code LSB.
- m_err out 1: frame-length error flag; qualified by m_valid.
- clip_lo_cnt out 16: present only with QUANT_CLIP_STATS_EN.
- clip_hi_cnt out 16: present only with QUANT_CLIP_STATS_EN.

## Operation
- Quantization (signed compare, feature index = current word index):
  - x < T0 -> 2'b00
  - T0 <= x < T1 -> 2'b01
  - T1 <= x < T2 -> 2'b10
  - x >= T2 -> 2'b11
- The FSM has two states, FILL and HOLD. Reset enters FILL with idx=0, m_data=0 and m_err=0.
- FILL:
  - s_ready=1 and m_valid=0.
  - On each accepted beat (s_valid & s_ready), the code is written to field idx.
  - If idx==NUM_FEATURES-1 or s_last=1: go to HOLD and set idx=0.
  - Otherwise idx increments by 1.
- Frame-length errors:
  - Early s_last (idx < NUM_FEATURES-1): fields above idx keep 2'b00 (cleared at frame start), and m_err=1.
  - Missing s_last on the NUM_FEATURES-th beat: the frame still closes, and m_err=1.
  - s_last exactly on the final beat: m_err=0.
- HOLD:
  - m_valid=1 and s_ready=0.
  - m_data and m_err stay stable until the handshake completes.
  - On m_valid & m_ready: return to FILL, clear m_data to 0 and m_err to 0.
- Input beats offered while s_ready=0 are not consumed; the upstream source holds its data.

## Timing
- Each code is registered on the accepting edge; no combinational path runs from s_data to m_data.
- Latency: if the final beat is accepted on edge k, m_valid=1 after edge k.
- s_ready is a pure function of state (FILL), so there is no combinational path from m_ready to s_ready.
- Throughput:
  - A full frame takes NUM_FEATURES accept cycles plus at least 1 HOLD cycle.
  - Back-to-back streaming with m_ready=1 gives one frame every NUM_FEATURES+1 cycles.
- m_ready asserted while in FILL is ignored.
- Asserting rst at any point (mid-frame or in HOLD) asynchronously forces:
  - state FILL and idx 0
  - m_valid=0, m_data=0, m_err=0
  - stat counters 0
- Any partial frame in progress at reset is discarded.
- Outputs become valid again only after a full new frame.

## Configuration
- QUANT_CLIP_STATS_EN defined:
  - Two 16-bit counters are instantiated. clip_lo_cnt increments on each accepted beat coded 2'b00; clip_hi_cnt increments on each accepted beat coded 2'b11.
  - Both counters saturate at 16'hFFFF and are cleared only by rst.
  - Counting includes beats of frames flagged with m_err.
- QUANT_CLIP_STATS_EN undefined: the counters and both ports are absent; all other behaviour is identical.

## Test plan
- Nominal frame, NUM_FEATURES=4, IN_W=8, thresholds (-16, 0, 16) for all features:
  - Stimulus: inputs -20, -1, 5, 100, with s_last on beat 4.
  - Required: m_valid one cycle after beat 4, m_data=8'b11_10_01_00, m_err=0.
- Threshold boundaries: inputs exactly -16, 0, 16, 15 -> codes 01, 10, 11, 10.
- Early s_last:
  - Stimulus: 2 beats (100, 100), s_last on beat 2.
  - Required: m_data=8'b00_00_11_11, m_err=1, s_ready=0 while HOLD.
- Backpressure:
  - Hold m_ready=0 for 10 cycles: m_data is stable, s_ready=0, and input beats are not consumed.
  - Then m_ready=1 for one cycle: FSM returns to FILL, and the next frame accepts from idx 0.
- Reset mid-frame:
  - Stimulus: assert rst after beat 2 of 4.
  - Required: m_valid=0 and m_data=0 immediately; the next 4 beats produce a clean frame with m_err=0.
- With QUANT_CLIP_STATS_EN:
  - Stimulus: the nominal frame streamed 3 times.
  - Required: clip_lo_cnt=3 and clip_hi_cnt=3.
  - Separately, force saturation and confirm both counters hold at 16'hFFFF.
